gray_ptr_sync: RTL
==================

// Module: gray_ptr_sync
// PURPOSE
//   Destination-domain receiver for a Gray-coded pointer crossing from another clock domain.
//   - Synchronises the bus through a parametrised flop chain.
//   - Converts it to binary, optionally with a registered output stage.
//   - Reports the per-cycle pointer advance and flags advances larger than allowed.
//   Sits on the read/write-pointer crossing of the async FIFO and replaces the bare
//   combinational Gray-to-binary converter.
// PARAMETERS
//   WIDTH        4  pointer width in bits (>=2)
//   SYNC_STAGES  2  synchroniser depth (>=2)
//   PIPE         1  1 = register bin_out after conversion; 0 = bin_out combinational from gray_out
//   MAX_STEP     1  largest legal per-cycle binary advance (1..2**WIDTH-1)
// PORTS
//   clk       input   1      destination-domain clock
//   rst_n     input   1      asynchronous active-low reset
//   gray_in   input   WIDTH  Gray pointer from source domain (asynchronous to clk)
//   err_clr   input   1      synchronous clear of step_err
//   gray_out  output  WIDTH  synchronised Gray pointer (last sync stage)
//   bin_out   output  WIDTH  binary equivalent of gray_out
//   ptr_valid output  1      bin_out/step meaningful
//   step      output  WIDTH  (bin_out - previous bin_out) mod 2**WIDTH
//   step_err  output  1      sticky: an advance > MAX_STEP was seen
// BEHAVIOUR
//   - Reset (rst_n low, async assert): all sync flops, gray_out, bin_out, prev-bin register,
//     step, ptr_valid and step_err go to 0. Release is taken on the next clk edge.
//   - Sync chain: gray_in is sampled on every rising clk edge.
//     - gray_out equals gray_in delayed by SYNC_STAGES edges.
//     - No logic is placed between sync flops.
//   - Conversion: bin[i] = XOR of gray_out[WIDTH-1:i].
//     - PIPE=1: bin_out is registered; latency gray_in->bin_out = SYNC_STAGES+1 edges.
//     - PIPE=0: bin_out is combinational from gray_out; latency = SYNC_STAGES edges.
//   - ptr_valid:
//     - A saturating counter counts LAT = SYNC_STAGES+PIPE edges after reset release.
//     - ptr_valid goes high on the edge the count reaches LAT and stays high until reset.
//   - step:
//     - A registered prev_bin captures bin_out every edge.
//     - step = bin_out - prev_bin (modulo WIDTH bits), registered.
//     - Wrap is natural: for WIDTH=4, 15 -> 0 gives step=1.
//     - step is forced to 0 while ptr_valid is low and on the first cycle ptr_valid is high,
//       so no false step appears from the reset value.
//   - step_err:
//     - Set on the edge after step > MAX_STEP is observed with ptr_valid high.
//     - Cleared only by err_clr or reset.
//     - If set and err_clr occur on the same edge, set wins.
//   - Hold: if gray_in is static, step = 0 and bin_out is constant.
//   - Reset mid-operation: all state returns to reset values immediately; the ptr_valid
//     count restarts from 0.
// STRUCTURE
//   Package gray_pkg holds:
//   - function gray2bin(logic [W-1:0]) and function bin2gray
//   - localparam SYNC_STAGES_MIN = 2
//   The package is shared with the FIFO pointer generators.
//   Sub-module sync_bus_ff (WIDTH, STAGES): a plain multi-bit flop chain with async
//   active-low reset, synchroniser attributes applied, no logic between stages.
//   Top level holds conversion, PIPE register, prev_bin, step arithmetic, valid counter and
//   error flag. Elaboration checks SYNC_STAGES>=2, WIDTH>=2 and 1<=MAX_STEP<2**WIDTH.
// TESTING
//   1. Reset-then-hold (defaults): drive gray_in=4'b0000 from reset release.
//      -> ptr_valid rises after exactly 3 edges; bin_out=0, step=0, step_err=0 throughout.
//   2. Single increments: walk gray_in 0000,0001,0011,0010, one per cycle.
//      -> bin_out 0,1,2,3 appears 3 edges later; step=1 each cycle; step_err stays 0.
//   3. Wrap: gray 1000 (bin 15) then 0000.
//      -> bin_out 15 -> 0, step=1, no error.
//   4. Over-step, MAX_STEP=1: jump gray 0000 -> 0010 (bin 3).
//      -> step=3, step_err=1 on the following edge.
//      -> Assert err_clr alone: step_err=0.
//      -> Repeat the jump with err_clr held high: step_err=1 (set wins).
//   5. Mid-run reset: pull rst_n low while bin_out=7.
//      -> All outputs are 0 immediately.
//      -> After release, ptr_valid takes another LAT edges; no step_err from the 7 -> 0 change.
//   6. Parameter sweep: WIDTH=6, SYNC_STAGES=3, PIPE=0.
//      -> Random monotonic Gray sequence with steps 0..1; scoreboard bin_out against
//         gray2bin delayed by 3 edges; step_err never asserts.

Source files
------------

// File: rtl/gray_pkg.sv
// Gray-code helpers and limits shared by the pointer synchroniser and the FIFO
// pointer generators.
// Callers zero-extend narrower pointers to PTR_W_MAX bits and truncate the
// result. Zero upper bits do not change either conversion.
package gray_pkg;

   localparam int unsigned SYNC_STAGES_MIN = 2;
   localparam int unsigned PTR_W_MAX       = 32;

   // bin[i] = XOR of g[MSB:i], built as a running XOR from the top bit down.
   function automatic logic [PTR_W_MAX-1:0] gray2bin(input logic [PTR_W_MAX-1:0] g);
      logic [PTR_W_MAX-1:0] b;
      b = '0;
      b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
      for (int i = int'(PTR_W_MAX) - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [PTR_W_MAX-1:0] bin2gray(input logic [PTR_W_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/sync_bus_ff.sv
// Multi-bit synchroniser flop chain, no logic between stages.
// Ports:
//   clk    destination clock
//   rst_n  async active-low reset, clears every stage
//   d      asynchronous input bus
//   q      output of the last stage
module sync_bus_ff #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];
   logic [WIDTH-1:0] sync_d [STAGES];

   // Plain shift: stage 0 samples d, every later stage copies its predecessor.
   always_comb begin
      sync_d = sync_q;
      sync_d[0] = d;
      for (int unsigned s = 1; s < STAGES; s++) begin
         sync_d[s] = sync_q[s-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Destination-domain receiver for a Gray-coded pointer: synchronise, convert to
// binary, report the per-cycle advance and flag advances above MAX_STEP.
// Ports:
//   clk, rst_n  destination clock, async active-low reset
//   gray_in     Gray pointer from the source domain
//   err_clr     synchronous clear of step_err
//   gray_out    synchronised Gray pointer (last sync stage)
//   bin_out     binary of gray_out (registered when PIPE=1)
//   ptr_valid   bin_out/step meaningful
//   step        bin_out - previous bin_out, modulo 2**WIDTH
//   step_err    sticky over-step flag
module gray_ptr_sync
   import gray_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PIPE        = 1,
   parameter int unsigned MAX_STEP    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             err_clr,
   output logic [WIDTH-1:0] gray_out,
   output logic [WIDTH-1:0] bin_out,
   output logic             ptr_valid,
   output logic [WIDTH-1:0] step,
   output logic             step_err
);

   localparam int unsigned LAT   = SYNC_STAGES + PIPE;
   localparam int unsigned CNT_W = $clog2(LAT + 1);

   if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_chk_sync
      $error("gray_ptr_sync: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
   end
   if (WIDTH < 2 || WIDTH > PTR_W_MAX) begin : g_chk_width
      $error("gray_ptr_sync: WIDTH must be in 2..%0d", PTR_W_MAX);
   end
   if (MAX_STEP < 1 || 64'(MAX_STEP) >= (64'd1 << WIDTH)) begin : g_chk_step
      $error("gray_ptr_sync: MAX_STEP must be in 1..2**WIDTH-1");
   end
   if (PIPE > 1) begin : g_chk_pipe
      $error("gray_ptr_sync: PIPE must be 0 or 1");
   end

   sync_bus_ff #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (gray_in),
      .q     (gray_out)
   );

   logic [WIDTH-1:0] bin_c;
   assign bin_c = WIDTH'(gray2bin(PTR_W_MAX'(gray_out)));

   // Optional register between converter and consumers.
   if (PIPE != 0) begin : g_pipe
      logic [WIDTH-1:0] bin_d;
      logic [WIDTH-1:0] bin_q;
      always_comb bin_d = bin_c;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) bin_q <= '0;
         else        bin_q <= bin_d;
      end
      assign bin_out = bin_q;
   end else begin : g_comb
      assign bin_out = bin_c;
   end

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             valid_dly_q, valid_dly_d;
   logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
   logic [WIDTH-1:0] step_q, step_d;
   logic             step_err_q, step_err_d;

   // valid_dly_q holds step at 0 for one extra cycle so the first real pointer
   // is never differenced against the reset value of prev_bin.
   always_comb begin
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      valid_dly_d = valid_q;
      prev_bin_d  = bin_out;
      step_d      = '0;
      step_err_d  = step_err_q;

      if (cnt_q != CNT_W'(LAT)) cnt_d = cnt_q + CNT_W'(1);
      valid_d = valid_q || (cnt_d == CNT_W'(LAT));

      if (valid_dly_q) step_d = bin_out - prev_bin_q;

      // Set is evaluated last so it wins over a simultaneous clear.
      if (err_clr) step_err_d = 1'b0;
      if (valid_q && (step_q > WIDTH'(MAX_STEP))) step_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         valid_q     <= 1'b0;
         valid_dly_q <= 1'b0;
         prev_bin_q  <= '0;
         step_q      <= '0;
         step_err_q  <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         valid_q     <= valid_d;
         valid_dly_q <= valid_dly_d;
         prev_bin_q  <= prev_bin_d;
         step_q      <= step_d;
         step_err_q  <= step_err_d;
      end
   end

   assign ptr_valid = valid_q;
   assign step      = step_q;
   assign step_err  = step_err_q;

endmodule
